clken_nco: RTL
==============

# clken_nco

Multi-channel fractional clock-enable generator driven by a single fabric clock. Each channel runs a phase accumulator (NCO) and emits single-cycle enable pulses at a runtime-programmable rate, plus a mid-period (180°) pulse. Channel rates are reprogrammed through a valid/ready port, and a PLL-style `locked` flag gates all enables while a reprogram settles. The block sits directly after the system PLL and replaces per-rate PLL outputs: it derives core, audio and video rates as enables on one clock.

## Interface
- `CHANNELS`, 3: number of enable channels, 1..8.
- `ACC_W`, 32: accumulator and step width, 8..48.
- `SETTLE`, 16: cycles `locked` stays low after reset or reprogram, ≥1.
- `DEFAULT_STEP`, {CHANNELS{32'h0}}: packed reset step per channel, channel 0 in the LSBs, width `CHANNELS*ACC_W`.

Ports:
- `refclk` in 1: sole clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = accumulators advance; 0 = accumulators hold and all enables are 0.
- `cfg_valid` in 1: reprogram request.
- `cfg_ready` out 1: block accepts a request this cycle.
- `cfg_chan` in max(1,$clog2(CHANNELS)): target channel.
- `cfg_step` in ACC_W: new step.
- `cfg_phase` in ACC_W: accumulator load value.
- `ce` out CHANNELS: per-channel enable pulse (wrap).
- `ce_180` out CHANNELS: per-channel mid-period pulse.
- `locked` out 1: configuration stable, enables live.

## Operation
- **Per-channel add:** each cycle, with `run`=1 and state ≠ APPLY, compute `{carry, acc_next} = acc + step` at ACC_W+1 bits. Then:
  - `acc <= acc_next`.
  - `wrap = carry`.
  - `half = ~acc[MSB] & acc_next[MSB] & ~carry`.
- **Enable outputs:** `ce[i] <= wrap & run & (state==LOCKED)`. `ce_180[i]` uses the same gating on `half`. Both are registered.
- **Step boundaries:**
  - step = 0: no pulses.
  - step ≥ 2^(ACC_W-1): `ce_180` follows the formula above and may never fire. This is legal.
- **FSM states:** SETTLE, LOCKED, APPLY.
  - Reset → SETTLE, with `cnt = SETTLE-1`.
  - SETTLE: if `cnt`==0 go to LOCKED, else decrement `cnt`.
  - LOCKED: hold.
  - Any state, on accept (`cfg_valid & cfg_ready`): capture chan/step/phase, go to APPLY.
  - APPLY (1 cycle): `acc[chan] <= cfg_phase`, `step[chan] <= cfg_step`, `cnt <= SETTLE-1`, go to SETTLE.
- **Handshake:**
  - `cfg_ready` = (state ≠ APPLY).
  - A request during SETTLE is accepted and restarts settling.
  - `cfg_valid` may drop without acceptance; no side effect.
- **Out-of-range channel:** `cfg_chan` ≥ CHANNELS is accepted and passes through APPLY/SETTLE. No accumulator or step changes.
- **APPLY freezes all accumulators:** every accumulator holds for that one cycle, including untargeted channels, so relative phase is preserved.
- **`locked` output:** `locked` = (state==LOCKED), registered.
- **Reset values:** acc = 0, step = DEFAULT_STEP, `ce`=0, `ce_180`=0, `locked`=0, `cfg_ready`=1. `rst_n` asserted mid-operation returns all of these immediately (asynchronously).

## Timing
- The FSM follows the last completed edge. Any edge with `cfg_valid & cfg_ready` = 1 is an accept and the FSM enters APPLY, independent of `run`.
- **After reset release:** `locked` rises on edge SETTLE (edges counted from the first edge after release).
- **After accept at edge T:**
  - APPLY is active between T and T+1, with `cfg_ready`=0.
  - Load occurs at edge T+1.
  - `locked`=0 from edge T. It rises at edge T+1+SETTLE, provided there is no further accept.
- **Pulse latency:** 1 cycle from the add to the `ce` pulse. The first pulse after lock requires a wrap occurring while LOCKED.
- **Throughput:** one accept every 2 cycles at most.
- **Average rate:** ce rate = f_refclk · step / 2^ACC_W exactly over any 2^ACC_W window. There is no drift or rounding accumulation.

## Structure
- **Shared package `clken_pkg`:**
  - FSM state enum (SETTLE/LOCKED/APPLY).
  - Helper function computing the step from target and reference frequency in Hz, for testbenches and top-level default calculation.
- **Sub-module `clken_nco_chan`:** one accumulator, step register, load port, and wrap/half outputs. It is instantiated CHANNELS times via generate.
- **Top level:** holds the FSM, settle counter, config capture and output gating.

## Test plan
- **Reset and settle:** reset with ACC_W=32, SETTLE=16, DEFAULT_STEP ch0=2^30 → `locked` rises on edge 16; `ce[0]` is then every 4th cycle and `ce_180[0]` sits 2 cycles after each `ce[0]`.
- **Reprogram:** while LOCKED, accept ch1 step=2^31, phase=0 → `cfg_ready`=0 for 1 cycle, `locked`=0 for 17 cycles; then `ce[1]` every 2nd cycle; ch0 phase is unchanged apart from the 1-cycle freeze.
- **Fractional rate:** step=0x2AAA_AAAB over 3·2^10 cycles → exactly 2^9 pulses of `ce`, with pulse spacing 5 or 6 cycles (never otherwise).
- **Boundaries:**
  - step=0 → no `ce`/`ce_180` ever.
  - `cfg_chan`=3 with CHANNELS=3 → locked drops and recovers; all steps are unchanged.
- **Back-to-back requests:** an accept during SETTLE restarts the count → `locked` is measured from the last APPLY; `run`=0 holds accumulators, gives `ce`=0, and rates resume on the same phase when `run` returns to 1.
- **Asynchronous reset:** assert `rst_n` mid-SETTLE and again mid-pulse between edges → all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Step helper rounds f_target/f_ref * 2^acc_w to the nearest integer.
package clken_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } clken_state_e;

  function automatic logic [63:0] step_from_hz(input real f_target_hz,
                                               input real f_ref_hz,
                                               input int unsigned acc_w);
    real scaled;
    scaled = (f_target_hz / f_ref_hz) * (2.0 ** acc_w);
    return longint'(scaled);
  endfunction

endpackage

// File: rtl/clken_nco_chan.sv
// One NCO channel: phase accumulator, step register, load port and wrap/half flags.
// wrap/half describe the add that the next advancing edge will commit.
module clken_nco_chan
  import clken_pkg::*;
#(
  parameter int                ACC_W    = 32,
  parameter logic [ACC_W-1:0]  RST_STEP = '0
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] load_step_i,
  input  logic [ACC_W-1:0] load_phase_i,
  output logic             wrap_o,
  output logic             half_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] step_q, step_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, step_q};
    wrap_o = sum[ACC_W];
    half_o = ~acc_q[ACC_W-1] & sum[ACC_W-1] & ~sum[ACC_W];
    acc_d  = acc_q;
    step_d = step_q;
    if (load_i) begin
      acc_d  = load_phase_i;
      step_d = load_step_i;
    end else if (adv_i) begin
      acc_d  = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      step_q <= RST_STEP;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/clken_nco.sv
// Multi-channel fractional clock-enable generator with PLL-style lock/settle
// sequencing around runtime reprogramming of channel steps and phases.
//   state      | meaning
//   ST_SETTLE  | counting down after reset/reprogram; enables suppressed
//   ST_LOCKED  | configuration stable; enables live
//   ST_APPLY   | one cycle: load captured step/phase, all accumulators frozen
module clken_nco
  import clken_pkg::*;
#(
  parameter int                          CHANNELS     = 3,
  parameter int                          ACC_W        = 32,
  parameter int                          SETTLE       = 16,
  parameter logic [CHANNELS*ACC_W-1:0]   DEFAULT_STEP = '0,
  localparam int                         CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]    cfg_step,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] ce_180,
  output logic                locked
);

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  clken_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHAN_W-1:0]   chan_q;
  logic [ACC_W-1:0]    step_q, phase_q;
  logic [CHANNELS-1:0] ce_q, ce_d, ce180_q, ce180_d;
  logic                locked_q;
  logic [CHANNELS-1:0] wrap, half;
  logic                accept, adv, is_locked;

  assign cfg_ready = (state_q != ST_APPLY);
  assign accept    = cfg_valid & cfg_ready;
  assign adv       = run & (state_q != ST_APPLY);
  assign is_locked = (state_q == ST_LOCKED);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clken_nco_chan #(
      .ACC_W    (ACC_W),
      .RST_STEP (DEFAULT_STEP[i*ACC_W +: ACC_W])
    ) u_chan (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .adv_i        (adv),
      .load_i       ((state_q == ST_APPLY) && (chan_q == CHAN_W'(i))),
      .load_step_i  (step_q),
      .load_phase_i (phase_q),
      .wrap_o       (wrap[i]),
      .half_o       (half[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_LOCKED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
        cnt_d   = CNT_INIT;
      end
      default: ;
    endcase
    // An accept overrides any settle progress, from any state that can accept.
    if (accept) state_d = ST_APPLY;
    ce_d    = wrap & {CHANNELS{run & is_locked}};
    ce180_d = half & {CHANNELS{run & is_locked}};
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= CNT_INIT;
      chan_q   <= '0;
      step_q   <= '0;
      phase_q  <= '0;
      ce_q     <= '0;
      ce180_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
      ce180_q  <= ce180_d;
      locked_q <= (state_d == ST_LOCKED);
      if (accept) begin
        chan_q  <= cfg_chan;
        step_q  <= cfg_step;
        phase_q <= cfg_phase;
      end
    end
  end

  assign ce     = ce_q;
  assign ce_180 = ce180_q;
  assign locked = locked_q;

endmodule
